// File: rtl/aes128_inv_cipher_iter.sv
// Iterative AES-128 decryption core: expands the key forward to K10, then runs one InvCipher round per clock.
// Build macro AES_INV_KEY_CACHE_EN keeps the last K0/K10 pair so a repeated key skips re-expansion.
module aes128_inv_cipher_iter #(
  parameter int unsigned NR       = 10,
  parameter logic [7:0]  RCON_INI = 8'h36
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] crypte,
  input  logic [0:127] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] message,
  output logic         busy
);
  typedef logic [0:127] block_t;
  typedef logic [0:31]  word_t;
  typedef enum logic [2:0] {IDLE, EXPAND, INIT, ROUND, FINAL, DONE} state_t;

  localparam logic [3:0] LAST_RND = 4'(NR);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      acc = gmul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic word_t sub_word(input word_t w);
    word_t r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sbox(w[8*i +: 8]);
    return r;
  endfunction

  function automatic block_t key_exp(input block_t k, input logic [7:0] rc);
    word_t w0, w1, w2, w3;
    w0 = k[0:31] ^ sub_word({k[104:127], k[96:103]}) ^ {rc, 24'h0};
    w1 = k[32:63] ^ w0;
    w2 = k[64:95] ^ w1;
    w3 = k[96:127] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic block_t inv_key_exp(input block_t k, input logic [7:0] rc);
    word_t w0, w1, w2, w3;
    w3 = k[96:127] ^ k[64:95];
    w2 = k[64:95] ^ k[32:63];
    w1 = k[32:63] ^ k[0:31];
    w0 = k[0:31] ^ sub_word({w3[8:31], w3[0:7]}) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  // Byte (row r, column c) sits at index 4c+r; row r rotates right by r columns.
  function automatic block_t inv_shift_rows(input block_t s);
    block_t r;
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++)
        r[8*(4*c + rw) +: 8] = s[8*(4*((c + 4 - rw) % 4) + rw) +: 8];
    return r;
  endfunction

  function automatic block_t inv_sub_bytes(input block_t s);
    block_t r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    return r;
  endfunction

  function automatic block_t inv_mix_columns(input block_t s);
    block_t r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c + 8 +: 8];
      a2 = s[32*c + 16 +: 8];
      a3 = s[32*c + 24 +: 8];
      r[32*c +: 8]      = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      r[32*c + 8 +: 8]  = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      r[32*c + 16 +: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      r[32*c + 24 +: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return r;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return RCON_INI;
      default: return 8'h00;
    endcase
  endfunction

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  block_t     st, st_nxt, kr, kr_nxt, msg_nxt;
  logic       ov_nxt;
  block_t     kr_fwd, kr_bwd, rnd_core;
  logic       cache_hit;
  block_t     hit_k10;

  assign kr_fwd   = key_exp(kr, rcon(cnt));
  assign kr_bwd   = inv_key_exp(kr, (state == INIT) ? RCON_INI : rcon(cnt));
  assign rnd_core = inv_sub_bytes(inv_shift_rows(st)) ^ kr;

  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    st_nxt    = st;
    kr_nxt    = kr;
    msg_nxt   = message;
    ov_nxt    = out_valid;
    unique case (state)
      IDLE: if (in_valid) begin
        st_nxt = crypte;
        if (cache_hit) begin
          kr_nxt    = hit_k10;
          state_nxt = INIT;
        end else begin
          kr_nxt    = key;
          cnt_nxt   = 4'd1;
          state_nxt = EXPAND;
        end
      end
      EXPAND: begin
        kr_nxt = kr_fwd;
        if (cnt == LAST_RND) state_nxt = INIT;
        else                 cnt_nxt   = cnt + 4'd1;
      end
      INIT: begin
        st_nxt    = st ^ kr;
        kr_nxt    = kr_bwd;
        cnt_nxt   = LAST_RND - 4'd1;
        state_nxt = ROUND;
      end
      ROUND: begin
        st_nxt = inv_mix_columns(rnd_core);
        kr_nxt = kr_bwd;
        if (cnt == 4'd1) state_nxt = FINAL;
        else             cnt_nxt   = cnt - 4'd1;
      end
      FINAL: begin
        msg_nxt   = rnd_core;
        ov_nxt    = 1'b1;
        state_nxt = DONE;
      end
      DONE: if (out_ready) begin
        ov_nxt    = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      message   <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      out_valid <= ov_nxt;
      message   <= msg_nxt;
    end
  end

  // NOTE: st/kr are wide datapath registers with no reset; they are always reloaded on accept.
  always_ff @(posedge clk) begin
    st <= st_nxt;
    kr <= kr_nxt;
  end

`ifdef AES_INV_KEY_CACHE_EN
  logic   cache_vld;
  block_t cache_k0, cache_k10;
  logic   cache_fill, expand_done;

  assign cache_hit   = cache_vld && (key == cache_k0);
  assign hit_k10     = cache_k10;
  assign cache_fill  = (state == IDLE) && in_valid && !cache_hit;
  assign expand_done = (state == EXPAND) && (cnt == LAST_RND);

  // The pair only becomes valid once the full forward expansion has completed.
  always_ff @(posedge clk) begin
    if (rst)              cache_vld <= 1'b0;
    else if (cache_fill)  cache_vld <= 1'b0;
    else if (expand_done) cache_vld <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (cache_fill)  cache_k0  <= key;
    if (expand_done) cache_k10 <= kr_fwd;
  end
`else
  assign cache_hit = 1'b0;
  assign hit_k10   = '0;
`endif

endmodule

// File: tb/tb_aes128_inv_cipher_iter.sv
// Directed and randomized bench for aes128_inv_cipher_iter against a word-based forward-cipher model.
module tb_aes128_inv_cipher_iter;
  typedef logic [0:127] blk_t;
  typedef struct {
    string name;
    blk_t  key;
    blk_t  ct;
    blk_t  pt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  blk_t crypte = '0;
  blk_t key = '0;
  logic in_ready, out_valid, busy;
  blk_t message;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] sb [256];
  logic cvld = 1'b0;
  blk_t ckey = '0;
  vec_t vecs [3];

  always #5 clk = ~clk;

  aes128_inv_cipher_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .crypte    (crypte),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .message   (message),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] tb_xt(input logic [7:0] a);
    return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
  endfunction

  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      p = tb_xt(p);
      if (b[i]) p = p ^ a;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, x, r;
    for (int v = 0; v < 256; v++) begin
      x   = 8'(v);
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (tb_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        r[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
      sb[v] = r ^ 8'h63;
    end
  endtask

  function automatic blk_t enc(input blk_t p, input blk_t k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [7:0]  b [16];
    logic [7:0]  a [16];
    blk_t s;
    for (int i = 0; i < 4; i++) w[i] = k[32*i +: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = tb_xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    s = p ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) b[i] = sb[s[8*i +: 8]];
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++) a[4*c + rw] = b[4*((c + rw) % 4) + rw];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          b[4*c]   = tb_mul(a[4*c], 8'h02) ^ tb_mul(a[4*c+1], 8'h03) ^ a[4*c+2] ^ a[4*c+3];
          b[4*c+1] = a[4*c] ^ tb_mul(a[4*c+1], 8'h02) ^ tb_mul(a[4*c+2], 8'h03) ^ a[4*c+3];
          b[4*c+2] = a[4*c] ^ a[4*c+1] ^ tb_mul(a[4*c+2], 8'h02) ^ tb_mul(a[4*c+3], 8'h03);
          b[4*c+3] = tb_mul(a[4*c], 8'h03) ^ a[4*c+1] ^ a[4*c+2] ^ tb_mul(a[4*c+3], 8'h02);
        end
        for (int i = 0; i < 16; i++) a[i] = b[i];
      end
      for (int i = 0; i < 16; i++) s[8*i +: 8] = a[i];
      s = s ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return s;
  endfunction

  // One full transaction; hold > 0 keeps out_ready low and pushes a competing request meanwhile.
  task automatic run_block(input string name, input blk_t k, input blk_t ct, input blk_t pt,
                           input int hold);
    int   lat;
    int   expl;
    blk_t held;
    expl = 21;
`ifdef AES_INV_KEY_CACHE_EN
    if (cvld && ckey == k) expl = 11;
`endif
    lat = 0;
    while (!in_ready && lat < 50) begin
      tick();
      lat++;
    end
    check({name, " in_ready"}, 128'(in_ready), 128'd1);
    crypte   = ct;
    key      = k;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    crypte   = ~ct;
    key      = ~k;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({name, " latency"}, 128'(lat), 128'(expl));
    check({name, " message"}, message, pt);
    held = message;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      crypte   = pt;
      key      = k;
      tick();
      check({name, " hold message"}, message, held);
      check({name, " hold out_valid"}, 128'(out_valid), 128'd1);
      check({name, " hold in_ready"}, 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({name, " released"}, 128'(out_valid), 128'd0);
    check({name, " idle after release"}, 128'(busy), 128'd0);
    tick();
    check({name, " single transfer"}, 128'(out_valid), 128'd0);
    cvld = 1'b1;
    ckey = k;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    blk_t k, p;
    vecs[0] = '{"fips_c1", 128'h000102030405060708090a0b0c0d0e0f,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff};
    vecs[1] = '{"fips_b", 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734};
    vecs[2] = '{"zero_key", 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0};
    build_sbox();

    repeat (3) tick();
    check("reset out_valid", 128'(out_valid), 128'd0);
    check("reset message", message, 128'h0);
    check("reset busy", 128'(busy), 128'd0);
    check("reset in_ready", 128'(in_ready), 128'd0);
    rst = 1'b0;
    #1;
    check("post-reset in_ready", 128'(in_ready), 128'd1);

    for (int i = 0; i < 3; i++)
      check({"model ", vecs[i].name}, enc(vecs[i].pt, vecs[i].key), vecs[i].ct);

    for (int i = 0; i < 3; i++)
      run_block(vecs[i].name, vecs[i].key, vecs[i].ct, vecs[i].pt, 0);

    run_block("repeat_c1_a", vecs[0].key, vecs[0].ct, vecs[0].pt, 0);
    run_block("repeat_c1_b", vecs[0].key, vecs[0].ct, vecs[0].pt, 0);
    run_block("new_key_b", vecs[1].key, vecs[1].ct, vecs[1].pt, 0);

    run_block("backpressure", vecs[1].key, vecs[1].ct, vecs[1].pt, 5);

    tick();
    crypte   = vecs[0].ct;
    key      = vecs[0].key;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    check("mid-op busy", 128'(busy), 128'd1);
    rst = 1'b1;
    tick();
    check("abort busy", 128'(busy), 128'd0);
    check("abort out_valid", 128'(out_valid), 128'd0);
    check("abort in_ready", 128'(in_ready), 128'd0);
    rst = 1'b0;
    cvld = 1'b0;
    #1;
    check("abort recover in_ready", 128'(in_ready), 128'd1);
    run_block("after_abort", vecs[0].key, vecs[0].ct, vecs[0].pt, 0);

    k = '0;
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      run_block("random", k, enc(p, k), p, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
